// File: rtl/cdb_mul_broadcaster_if.sv
// Issue and CDB signal bundle between a reservation station/arbiter and the
// multiply-then-broadcast unit.
interface cdb_mul_broadcaster_if #(
    parameter int WIDTH = 16
);
    logic             issue_valid;
    logic             issue_ready;
    logic [2:0]       issue_tag;
    logic [WIDTH-1:0] issue_vj;
    logic [WIDTH-1:0] issue_vk;
    logic             issue_op;
    logic             cdb_req;
    logic             cdb_grant;
    logic             cdb_valid;
    logic [2:0]       cdb_tag;
    logic [WIDTH-1:0] CDB;
    logic             tag_err;

    modport master (
        output issue_valid, issue_tag, issue_vj, issue_vk, issue_op, cdb_grant,
        input  issue_ready, cdb_req, cdb_valid, cdb_tag, CDB, tag_err
    );

    modport slave (
        input  issue_valid, issue_tag, issue_vj, issue_vk, issue_op, cdb_grant,
        output issue_ready, cdb_req, cdb_valid, cdb_tag, CDB, tag_err
    );
endinterface

// File: rtl/cdb_mul_broadcaster.sv
// Fixed-latency unsigned multiplier feeding a FIFO of tagged results that
// are broadcast on the CDB one per grant, in acceptance order.
module cdb_mul_broadcaster #(
    parameter int WIDTH  = 16,
    parameter int LAT    = 3,
    parameter int QDEPTH = 4
) (
    input logic                    Clock,
    input logic                    Resetn,
    cdb_mul_broadcaster_if.slave   bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] QD = (CW+1)'(QDEPTH);

    logic [LAT-1:0]                r_vld_pipe;
    logic [LAT-1:0][2:0]           r_tag_pipe;
    logic [LAT-1:0][WIDTH-1:0]     r_res_pipe;
    logic [QDEPTH-1:0][2:0]        r_q_tag;
    logic [QDEPTH-1:0][WIDTH-1:0]  r_q_data;
    logic [PW-1:0]                 r_wptr, r_rptr;
    logic [CW-1:0]                 r_count, r_inflight;
    logic                          r_tag_err;

    logic [CW:0]                   w_occ;
    logic                          w_try, w_acc, w_push, w_pop, w_req;
    logic [2*WIDTH-1:0]            w_prod;
    logic [WIDTH-1:0]              w_res;

    // Reservation counts every in-flight op, so the pipeline never needs to stall
    assign w_occ  = {1'b0, r_count} + {1'b0, r_inflight};
    assign bus.issue_ready = (w_occ < QD);

    assign w_try  = bus.issue_valid & bus.issue_ready;
    assign w_acc  = w_try & (bus.issue_tag != 3'd0);
    assign w_prod = {{WIDTH{1'b0}}, bus.issue_vj} * {{WIDTH{1'b0}}, bus.issue_vk};
    assign w_res  = bus.issue_op ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];

    assign w_push = r_vld_pipe[LAT-1];
    assign w_req  = (r_count != '0);
    assign w_pop  = w_req & bus.cdb_grant;

    assign bus.cdb_req   = w_req;
    assign bus.cdb_valid = w_pop;
    assign bus.cdb_tag   = w_req ? r_q_tag[r_rptr]  : 3'd0;
    assign bus.CDB       = w_req ? r_q_data[r_rptr] : '0;
    assign bus.tag_err   = r_tag_err;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_vld_pipe <= '0;
            r_tag_pipe <= '0;
            r_res_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= w_acc;
            r_tag_pipe[0] <= bus.issue_tag;
            r_res_pipe[0] <= w_res;
            for (int i = 1; i < LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_tag_pipe[i] <= r_tag_pipe[i-1];
                r_res_pipe[i] <= r_res_pipe[i-1];
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_inflight <= '0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_q_tag    <= '0;
            r_q_data   <= '0;
            r_tag_err  <= 1'b0;
        end else begin
            case ({w_acc, w_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push) begin
                r_q_tag[r_wptr]  <= r_tag_pipe[LAT-1];
                r_q_data[r_wptr] <= r_res_pipe[LAT-1];
                r_wptr           <= r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_try && bus.issue_tag == 3'd0)
                r_tag_err <= 1'b1;
        end
    end

    a_no_overflow: assert property (@(posedge Clock) disable iff (!Resetn)
        !(w_push && !w_pop && r_count == CW'(QDEPTH)));
endmodule

// File: tb/tb_cdb_mul_broadcaster.sv
// Directed bench for the multiply/CDB broadcaster: latency, product halves,
// backpressure, streaming order, tag-0 error and mid-flight reset.
module tb_cdb_mul_broadcaster;
    localparam int W = 16;

    logic Clock = 1'b0;
    logic Resetn;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 Clock = ~Clock;

    cdb_mul_broadcaster_if #(.WIDTH(W)) bus();

    cdb_mul_broadcaster #(.WIDTH(W), .LAT(3), .QDEPTH(4)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus.slave)
    );

    task automatic drive_idle;
        bus.issue_valid = 1'b0;
        bus.issue_tag   = 3'd0;
        bus.issue_vj    = '0;
        bus.issue_vk    = '0;
        bus.issue_op    = 1'b0;
    endtask

    // Called just after a negedge; presents one op across the next rising edge.
    task automatic do_issue(input logic [2:0] t, input logic [W-1:0] a, input logic [W-1:0] b, input logic o);
        bus.issue_valid = 1'b1;
        bus.issue_tag   = t;
        bus.issue_vj    = a;
        bus.issue_vk    = b;
        bus.issue_op    = o;
        @(negedge Clock);
        bus.issue_valid = 1'b0;
    endtask

    task automatic test_reset;
        drive_idle();
        bus.cdb_grant = 1'b1;
        Resetn = 1'b0;
        #1;
        n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", bus.issue_ready); end
        n_checks++; if (bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", bus.cdb_req); end
        n_checks++; if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", bus.cdb_valid); end
        n_checks++; if (bus.cdb_tag !== 3'd0 || bus.CDB !== 16'h0) begin n_fail++; $display("FAIL rst_bus: got tag %0d data %h exp 0/0000", bus.cdb_tag, bus.CDB); end
        n_checks++; if (bus.tag_err !== 1'b0) begin n_fail++; $display("FAIL rst_tag_err: got %b exp 0", bus.tag_err); end
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        n_checks++; if (bus.issue_ready !== 1'b1 || bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL post_rst: got ready %b req %b exp 1/0", bus.issue_ready, bus.cdb_req); end
    endtask

    task automatic test_latency;
        bus.cdb_grant = 1'b1;
        do_issue(3'd2, 16'd3, 16'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early c%0d: got valid %b exp 0", i, bus.cdb_valid); end
            @(negedge Clock);
        end
        n_checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 3'd2 || bus.CDB !== 16'h000F) begin n_fail++; $display("FAIL lat_bcast: got v%b tag %0d data %h exp v1 tag 2 000f", bus.cdb_valid, bus.cdb_tag, bus.CDB); end
        @(negedge Clock);
        n_checks++; if (bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL lat_drain: got req %b exp 0", bus.cdb_req); end
    endtask

    task automatic test_ops;
        bus.cdb_grant = 1'b0;
        do_issue(3'd5, 16'h1234, 16'h0100, 1'b1);
        do_issue(3'd6, 16'h1234, 16'h0100, 1'b0);
        repeat (3) @(negedge Clock);
        n_checks++; if (bus.cdb_req !== 1'b1 || bus.cdb_tag !== 3'd5 || bus.CDB !== 16'h0012) begin n_fail++; $display("FAIL op_high: got req %b tag %0d data %h exp 1/5/0012", bus.cdb_req, bus.cdb_tag, bus.CDB); end
        n_checks++; if (bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL op_nogrant: got valid %b exp 0", bus.cdb_valid); end
        bus.cdb_grant = 1'b1;
        #1;
        n_checks++; if (bus.cdb_valid !== 1'b1) begin n_fail++; $display("FAIL op_grant: got valid %b exp 1", bus.cdb_valid); end
        @(negedge Clock);
        n_checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 3'd6 || bus.CDB !== 16'h3400) begin n_fail++; $display("FAIL op_low: got v%b tag %0d data %h exp v1 tag 6 3400", bus.cdb_valid, bus.cdb_tag, bus.CDB); end
        @(negedge Clock);
        n_checks++; if (bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL op_drain: got req %b exp 0", bus.cdb_req); end
        bus.cdb_grant = 1'b0;
    endtask

    task automatic test_backpressure;
        bus.cdb_grant = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready%0d: got %b exp 1", t, bus.issue_ready); end
            do_issue(3'(t), 16'(t), 16'd1, 1'b0);
        end
        n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got ready %b exp 0", bus.issue_ready); end
        bus.issue_valid = 1'b1;
        bus.issue_tag   = 3'd5;
        repeat (4) @(negedge Clock);
        bus.issue_valid = 1'b0;
        n_checks++; if (bus.issue_ready !== 1'b0 || bus.cdb_tag !== 3'd1) begin n_fail++; $display("FAIL bp_hold: got ready %b tag %0d exp 0/1", bus.issue_ready, bus.cdb_tag); end
        bus.cdb_grant = 1'b1;
        #1;
        n_checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 3'd1 || bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL bp_pop: got v%b tag %0d ready %b exp 1/1/0", bus.cdb_valid, bus.cdb_tag, bus.issue_ready); end
        @(negedge Clock);
        bus.cdb_grant = 1'b0;
        n_checks++; if (bus.issue_ready !== 1'b1 || bus.cdb_tag !== 3'd2) begin n_fail++; $display("FAIL bp_free: got ready %b tag %0d exp 1/2", bus.issue_ready, bus.cdb_tag); end
        bus.cdb_grant = 1'b1;
        for (int t = 2; t <= 4; t++) begin
            #1;
            n_checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 3'(t) || bus.CDB !== 16'(t)) begin n_fail++; $display("FAIL bp_drain%0d: got v%b tag %0d data %h", t, bus.cdb_valid, bus.cdb_tag, bus.CDB); end
            @(negedge Clock);
        end
        n_checks++; if (bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got req %b exp 0 (5th op accepted?)", bus.cdb_req); end
        bus.cdb_grant = 1'b0;
    endtask

    task automatic test_stream;
        logic [2:0]   exp_tag[$];
        logic [W-1:0] exp_dat[$];
        logic [2*W-1:0] p;
        logic [W-1:0] a, b;
        int n_iss = 0;
        int n_rcv = 0;
        bus.cdb_grant = 1'b1;
        for (int cyc = 0; cyc < 80 && n_rcv < 12; cyc++) begin
            if (bus.cdb_valid) begin
                n_checks++;
                if (exp_tag.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra: got tag %0d with nothing pending", bus.cdb_tag);
                end else begin
                    if (bus.cdb_tag !== exp_tag[0] || bus.CDB !== exp_dat[0]) begin
                        n_fail++; $display("FAIL stream_order: got tag %0d data %h exp tag %0d data %h", bus.cdb_tag, bus.CDB, exp_tag[0], exp_dat[0]);
                    end
                    void'(exp_tag.pop_front());
                    void'(exp_dat.pop_front());
                end
                n_rcv++;
            end
            if (bus.issue_ready && n_iss < 12) begin
                a = 16'(100 * n_iss + 7);
                b = 16'(313 * n_iss + 1);
                p = {16'h0, a} * {16'h0, b};
                bus.issue_valid = 1'b1;
                bus.issue_tag   = 3'(n_iss % 7 + 1);
                bus.issue_vj    = a;
                bus.issue_vk    = b;
                bus.issue_op    = n_iss[0];
                exp_tag.push_back(3'(n_iss % 7 + 1));
                exp_dat.push_back(n_iss[0] ? p[31:16] : p[15:0]);
                n_iss++;
            end else begin
                bus.issue_valid = 1'b0;
            end
            @(negedge Clock);
        end
        bus.issue_valid = 1'b0;
        n_checks++; if (n_rcv != 12 || exp_tag.size() != 0) begin n_fail++; $display("FAIL stream_count: got %0d broadcasts, %0d pending, exp 12/0", n_rcv, exp_tag.size()); end
        repeat (4) @(negedge Clock);
        n_checks++; if (bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL stream_dup: got req %b exp 0", bus.cdb_req); end
    endtask

    task automatic test_tag_err;
        bus.cdb_grant = 1'b1;
        do_issue(3'd0, 16'd9, 16'd9, 1'b0);
        n_checks++; if (bus.tag_err !== 1'b1) begin n_fail++; $display("FAIL tag_err_set: got %b exp 1", bus.tag_err); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (bus.cdb_valid !== 1'b0 || bus.tag_err !== 1'b1) begin n_fail++; $display("FAIL tag_err_hold c%0d: got valid %b err %b exp 0/1", i, bus.cdb_valid, bus.tag_err); end
            @(negedge Clock);
        end
        Resetn = 1'b0;
        #1;
        n_checks++; if (bus.tag_err !== 1'b0) begin n_fail++; $display("FAIL tag_err_clr: got %b exp 0", bus.tag_err); end
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_reset_mid;
        bus.cdb_grant = 1'b1;
        do_issue(3'd3, 16'd2, 16'd2, 1'b0);
        do_issue(3'd4, 16'd3, 16'd3, 1'b0);
        do_issue(3'd5, 16'd4, 16'd4, 1'b0);
        Resetn = 1'b0;
        #1;
        n_checks++; if (bus.issue_ready !== 1'b1 || bus.cdb_req !== 1'b0 || bus.cdb_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctl: got ready %b req %b valid %b exp 1/0/0", bus.issue_ready, bus.cdb_req, bus.cdb_valid); end
        n_checks++; if (bus.cdb_tag !== 3'd0 || bus.CDB !== 16'h0) begin n_fail++; $display("FAIL mid_rst_bus: got tag %0d data %h exp 0/0000", bus.cdb_tag, bus.CDB); end
        @(negedge Clock);
        Resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            n_checks++; if (bus.cdb_valid !== 1'b0 || bus.cdb_req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ghost c%0d: got valid %b req %b exp 0/0", i, bus.cdb_valid, bus.cdb_req); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_ops();
        test_backpressure();
        test_stream();
        test_tag_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
